// File: rtl/prf_timing_pkg.sv
// Shared definitions for the PRF timing generator.
// Holds the mode encodings, the controller state encoding, the channel-count
// limit and the configuration validity rule used on every update.
package prf_timing_pkg;

    localparam int unsigned NCH_MAX = 16;

    localparam logic [1:0] MODE_CONT  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // A configuration is usable when the period is at least 2 clocks and the
    // mode is continuous, or burst with a non-zero burst length.
    function automatic logic cfg_ok(input logic [1:0] mode,
                                    input logic       period_ge2,
                                    input logic       burst_nonzero);
        return period_ge2 &&
               ((mode == MODE_CONT) || ((mode == MODE_BURST) && burst_nonzero));
    endfunction

endpackage

// File: rtl/prf_chan_win.sv
// One timing channel: window compare against the period counter, registered
// pulse output and registered edge strobes.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   run               controller is in RUN
//   cnt               period counter
//   delay, width      active window start and length
//   ch_out            registered pulse (1 clock after cnt)
//   ch_rise, ch_fall  edge strobes of ch_out, 1 clock after ch_out
module prf_chan_win #(
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width,
    output logic          ch_out,
    output logic          ch_rise,
    output logic          ch_fall
);

    logic [CW:0] win_end;
    logic        in_win;
    logic        out_q;
    logic        prev_q;
    logic        rise_q;
    logic        fall_q;

    // The end is computed one bit wider so delay+width cannot wrap. Because
    // cnt never reaches the period, the window is implicitly clipped there.
    assign win_end = {1'b0, delay} + {1'b0, width};
    assign in_win  = run && (cnt >= delay) && ({1'b0, cnt} < win_end);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q  <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            out_q  <= in_win;
            prev_q <= out_q;
            rise_q <= out_q & ~prev_q;
            fall_q <= ~out_q & prev_q;
        end
    end

    assign ch_out  = out_q;
    assign ch_rise = rise_q;
    assign ch_fall = fall_q;

endmodule

// File: rtl/prf_timing_gen.sv
// PRF timing generator: a period counter drives NCH delayed/width-limited
// channel pulses, a PRF marker and a calibration gate, in continuous or
// burst mode. Configuration is double-buffered: updates while running are
// held pending and take effect at the next period boundary.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   update                     strobe: capture config ports
//   enable                     run request (level)
//   mode, period, burst_len    mode (01 cont, 10 burst), period, periods per burst
//   ch_delay, ch_width         per-channel window, channel k at [k*CW +: CW]
//   ct_len                     calibration gate length
//   prf, ch_out, ch_rise, ch_fall, ct   registered timing outputs
//   busy, burst_done, cfg_err  RUN status, burst-end strobe, sticky config error
module prf_timing_gen
    import prf_timing_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     period,
    input  logic [15:0]       burst_len,
    input  logic [NCH*CW-1:0] ch_delay,
    input  logic [NCH*CW-1:0] ch_width,
    input  logic [CW-1:0]     ct_len,
    output logic              prf,
    output logic [NCH-1:0]    ch_out,
    output logic [NCH-1:0]    ch_rise,
    output logic [NCH-1:0]    ch_fall,
    output logic              ct,
    output logic              busy,
    output logic              burst_done,
    output logic              cfg_err
);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [15:0]       burst_cnt_q, burst_cnt_d;
    logic [CW-1:0]     ct_rem_q, ct_rem_d;
    logic              done_lock_q, done_lock_d;
    logic              burst_end_q, burst_end_d;
    logic              burst_done_q, prf_q, ct_q, busy_q, cfg_err_q;

    logic              act_valid_q, pend_valid_q;
    logic [1:0]        act_mode_q, pend_mode_q;
    logic [CW-1:0]     act_period_q, pend_period_q;
    logic [15:0]       act_burst_len_q, pend_burst_len_q;
    logic [NCH*CW-1:0] act_delay_q, pend_delay_q;
    logic [NCH*CW-1:0] act_width_q, pend_width_q;
    logic [CW-1:0]     act_ct_len_q, pend_ct_len_q;

    logic              run, wrap, upd_ok, apply_pend;

    assign run    = (state_q == StRun);
    assign wrap   = (cnt_q == act_period_q - CW'(1));
    assign upd_ok = cfg_ok(mode, period >= CW'(2), burst_len != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_cnt_d = burst_cnt_q;
        ct_rem_d    = ct_rem_q;
        burst_end_d = 1'b0;
        // Lockout after a burst holds until enable is seen low.
        done_lock_d = done_lock_q & enable;
        apply_pend  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && act_valid_q && !done_lock_q) begin
                    state_d     = StRun;
                    cnt_d       = '0;
                    burst_cnt_d = '0;
                    ct_rem_d    = act_ct_len_q;
                end
            end
            StRun: begin
                if (ct_rem_q != '0) begin
                    ct_rem_d = ct_rem_q - CW'(1);
                end
                if (wrap) begin
                    cnt_d      = '0;
                    apply_pend = pend_valid_q;
                    if (act_mode_q == MODE_BURST) begin
                        if (burst_cnt_q + 16'd1 >= act_burst_len_q) begin
                            state_d     = StIdle;
                            burst_end_d = 1'b1;
                            done_lock_d = enable;
                        end else begin
                            burst_cnt_d = burst_cnt_q + 16'd1;
                        end
                    end
                    // Enable is only honoured at the boundary so no pulse is cut short.
                    if (!enable) begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            burst_cnt_q  <= '0;
            ct_rem_q     <= '0;
            done_lock_q  <= 1'b0;
            burst_end_q  <= 1'b0;
            burst_done_q <= 1'b0;
            prf_q        <= 1'b0;
            ct_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            ct_rem_q     <= ct_rem_d;
            done_lock_q  <= done_lock_d;
            prf_q        <= run && (cnt_q == '0);
            ct_q         <= run && (ct_rem_q != '0);
            busy_q       <= run;
            // Two stages so the strobe lines up with busy falling.
            burst_end_q  <= burst_end_d;
            burst_done_q <= burst_end_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_err_q        <= 1'b0;
            act_valid_q      <= 1'b0;
            act_mode_q       <= '0;
            act_period_q     <= '0;
            act_burst_len_q  <= '0;
            act_delay_q      <= '0;
            act_width_q      <= '0;
            act_ct_len_q     <= '0;
            pend_valid_q     <= 1'b0;
            pend_mode_q      <= '0;
            pend_period_q    <= '0;
            pend_burst_len_q <= '0;
            pend_delay_q     <= '0;
            pend_width_q     <= '0;
            pend_ct_len_q    <= '0;
        end else begin
            if (apply_pend) begin
                act_valid_q     <= 1'b1;
                act_mode_q      <= pend_mode_q;
                act_period_q    <= pend_period_q;
                act_burst_len_q <= pend_burst_len_q;
                act_delay_q     <= pend_delay_q;
                act_width_q     <= pend_width_q;
                act_ct_len_q    <= pend_ct_len_q;
                pend_valid_q    <= 1'b0;
            end
            // An update on the boundary cycle lands in pending for the next one.
            if (update) begin
                if (!upd_ok) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    cfg_err_q <= 1'b0;
                    if (state_q == StIdle) begin
                        act_valid_q     <= 1'b1;
                        act_mode_q      <= mode;
                        act_period_q    <= period;
                        act_burst_len_q <= burst_len;
                        act_delay_q     <= ch_delay;
                        act_width_q     <= ch_width;
                        act_ct_len_q    <= ct_len;
                    end else begin
                        pend_valid_q     <= 1'b1;
                        pend_mode_q      <= mode;
                        pend_period_q    <= period;
                        pend_burst_len_q <= burst_len;
                        pend_delay_q     <= ch_delay;
                        pend_width_q     <= ch_width;
                        pend_ct_len_q    <= ct_len;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        prf_chan_win #(
            .CW(CW)
        ) u_chan_win (
            .clk    (clk),
            .rst    (rst),
            .run    (run),
            .cnt    (cnt_q),
            .delay  (act_delay_q[k*CW +: CW]),
            .width  (act_width_q[k*CW +: CW]),
            .ch_out (ch_out[k]),
            .ch_rise(ch_rise[k]),
            .ch_fall(ch_fall[k])
        );
    end

    assign prf        = prf_q;
    assign ct         = ct_q;
    assign busy       = busy_q;
    assign burst_done = burst_done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_prf_timing_gen.sv
module tb_prf_timing_gen;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 32;

    logic              clk = 1'b0;
    logic              rst, update, enable;
    logic [1:0]        mode;
    logic [CW-1:0]     period;
    logic [15:0]       burst_len;
    logic [NCH*CW-1:0] ch_delay, ch_width;
    logic [CW-1:0]     ct_len;
    logic              prf, ct, busy, burst_done, cfg_err;
    logic [NCH-1:0]    ch_out, ch_rise, ch_fall;

    always #5 clk = ~clk;

    prf_timing_gen #(
        .NCH(NCH),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .update    (update),
        .enable    (enable),
        .mode      (mode),
        .period    (period),
        .burst_len (burst_len),
        .ch_delay  (ch_delay),
        .ch_width  (ch_width),
        .ct_len    (ct_len),
        .prf       (prf),
        .ch_out    (ch_out),
        .ch_rise   (ch_rise),
        .ch_fall   (ch_fall),
        .ct        (ct),
        .busy      (busy),
        .burst_done(burst_done),
        .cfg_err   (cfg_err)
    );

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    // Behavioural reference: time-stamp based. The current phase is time since
    // the period began; the gate is time since the run began.
    bit       m_run, m_lock, m_err, m_end_q;
    longint   m_t, m_run_t0, m_per_t0, m_ctlen;
    int       m_bper;
    bit       a_valid, p_valid;
    int       a_mode, p_mode, a_blen, p_blen;
    longint   a_per, p_per, a_ct, p_ct;
    longint   a_dly [NCH];
    longint   a_wid [NCH];
    longint   p_dly [NCH];
    longint   p_wid [NCH];
    bit       e_prf, e_ct, e_busy, e_done;
    bit [NCH-1:0] e_ch, e_ch_prev, e_rise, e_fall;

    always @(posedge clk) begin : model
        longint       ph;
        bit           wrap, start, was_run, ok;
        bit [NCH-1:0] nch;
        if (!rst) begin
            m_run = 0; m_lock = 0; m_err = 0; m_end_q = 0; m_bper = 0;
            a_valid = 0; p_valid = 0;
            e_prf = 0; e_ct = 0; e_busy = 0; e_done = 0;
            e_ch = '0; e_ch_prev = '0; e_rise = '0; e_fall = '0;
        end else begin
            ph  = m_t - m_per_t0;
            nch = '0;
            for (int k = 0; k < NCH; k++)
                if (m_run && ph >= a_dly[k] && ph < a_dly[k] + a_wid[k]) nch[k] = 1'b1;
            e_rise    = e_ch & ~e_ch_prev;
            e_fall    = ~e_ch & e_ch_prev;
            e_ch_prev = e_ch;
            e_ch      = nch;
            e_prf     = m_run && (ph == 0);
            e_ct      = m_run && ((m_t - m_run_t0) < m_ctlen);
            e_busy    = m_run;
            e_done    = m_end_q;
            m_end_q   = 0;
            was_run   = m_run;
            wrap      = m_run && (ph == a_per - 1);
            start     = !m_run && enable && a_valid && !m_lock;
            m_lock    = m_lock && enable;
            if (wrap) begin
                if (a_mode == 2) begin
                    m_bper++;
                    if (m_bper >= a_blen) begin
                        m_run = 0; m_end_q = 1; m_lock = enable;
                    end
                end
                if (!enable) m_run = 0;
                m_per_t0 = m_t + 1;
                if (p_valid) begin
                    a_mode = p_mode; a_per = p_per; a_blen = p_blen; a_ct = p_ct;
                    a_dly = p_dly; a_wid = p_wid; p_valid = 0;
                end
            end else if (start) begin
                m_run = 1; m_run_t0 = m_t + 1; m_per_t0 = m_t + 1; m_bper = 0; m_ctlen = a_ct;
            end
            if (update) begin
                ok = (period >= 2) && (mode == 2'b01 || (mode == 2'b10 && burst_len != 0));
                if (!ok) m_err = 1;
                else begin
                    m_err = 0;
                    if (!was_run) begin
                        a_valid = 1; a_mode = int'(mode); a_per = longint'(period);
                        a_blen = int'(burst_len); a_ct = longint'(ct_len);
                        for (int k = 0; k < NCH; k++) begin
                            a_dly[k] = longint'(ch_delay[k*CW +: CW]);
                            a_wid[k] = longint'(ch_width[k*CW +: CW]);
                        end
                    end else begin
                        p_valid = 1; p_mode = int'(mode); p_per = longint'(period);
                        p_blen = int'(burst_len); p_ct = longint'(ct_len);
                        for (int k = 0; k < NCH; k++) begin
                            p_dly[k] = longint'(ch_delay[k*CW +: CW]);
                            p_wid[k] = longint'(ch_width[k*CW +: CW]);
                        end
                    end
                end
            end
        end
        m_t++;
    end

    logic [3*NCH+4:0] exp_v, act_v;

    always @(posedge clk) begin
        #1;
        exp_v = {e_prf, e_ch, e_rise, e_fall, e_ct, e_busy, e_done, m_err};
        act_v = {prf, ch_out, ch_rise, ch_fall, ct, busy, burst_done, cfg_err};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs @%0t: got %h expected %h", $time, act_v, exp_v);
        end
    end

    function automatic longint outs_now();
        return longint'({prf, ch_out, ch_rise, ch_fall, ct, busy, burst_done, cfg_err});
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        tcyc++;
    endtask

    task automatic wait_prf(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (prf) begin
                at = tcyc;
                break;
            end
        end
        if (at < 0) chk("prf_timeout", 0, 1);
    endtask

    task automatic wait_busy(input logic lvl, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (busy == lvl) begin
                at = tcyc;
                break;
            end
        end
        if (at < 0) chk("busy_timeout", 0, 1);
    endtask

    task automatic do_update(input int md, input longint per, input int bl,
                             input longint d0, input longint w0, input longint ctl);
        mode      = 2'(md);
        period    = CW'(per);
        burst_len = 16'(bl);
        ct_len    = CW'(ctl);
        ch_delay[0 +: CW] = CW'(d0);
        ch_width[0 +: CW] = CW'(w0);
        for (int k = 1; k < NCH; k++) begin
            ch_delay[k*CW +: CW] = CW'($urandom_range(0, 12));
            ch_width[k*CW +: CW] = CW'($urandom_range(0, 6));
        end
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    initial begin
        int p, q0, p2, p3, p4, p5, b, fall_at, done_at, np, nd, nr, nf, nb;
        bit h [0:12];
        rst = 0; update = 0; enable = 0; mode = '0; period = '0; burst_len = '0;
        ch_delay = '0; ch_width = '0; ct_len = '0;
        repeat (3) step();
        chk("reset_outputs", outs_now(), 0);

        // No start without an update after reset.
        rst = 1; enable = 1; nb = 0;
        repeat (8) begin step(); nb += int'(busy); end
        chk("no_start_without_update", nb, 0);

        // Continuous, period 10, ch0 delay 2 width 3.
        enable = 0;
        do_update(1, 10, 1, 2, 3, 0);
        enable = 1;
        wait_prf(30, p);
        np = 0; nr = 0; nf = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            h[i] = ch_out[0];
            nr += int'(ch_rise[0]);
            nf += int'(ch_fall[0]);
            if (i < 10) np += int'(prf);
        end
        chk("ch0_cnt1_low", longint'(h[1]), 0);
        chk("ch0_cnt2_high", longint'(h[2]), 1);
        chk("ch0_cnt4_high", longint'(h[4]), 1);
        chk("ch0_cnt5_low", longint'(h[5]), 0);
        chk("prf_at_10", longint'(prf), 1);
        chk("no_prf_between", np, 0);
        chk("rise_once", nr, 1);
        chk("fall_once", nf, 1);

        // Period change issued at cnt 4 takes effect at the boundary.
        q0 = tcyc;
        repeat (3) step();
        do_update(1, 20, 1, 2, 3, 0);
        wait_prf(30, p2);
        chk("old_period_completes", p2 - q0, 10);
        wait_prf(40, p3);
        chk("new_period_20", p3 - p2, 20);

        // Invalid update leaves the running config untouched.
        do_update(1, 1, 1, 2, 3, 0);
        chk("cfg_err_set", longint'(cfg_err), 1);
        wait_prf(40, p4);
        wait_prf(40, p5);
        chk("period_unchanged", p5 - p4, 20);
        do_update(1, 10, 1, 2, 3, 0);
        chk("cfg_err_cleared", longint'(cfg_err), 0);

        // Window clipped at the period end.
        enable = 0;
        wait_busy(1'b0, 60, b);
        do_update(1, 10, 1, 8, 5, 0);
        enable = 1;
        wait_prf(30, p);
        for (int i = 1; i <= 12; i++) begin step(); h[i] = ch_out[0]; end
        chk("clip_cnt7_low", longint'(h[7]), 0);
        chk("clip_cnt8_high", longint'(h[8]), 1);
        chk("clip_cnt9_high", longint'(h[9]), 1);
        chk("clip_next0_low", longint'(h[10]), 0);
        chk("clip_next2_low", longint'(h[12]), 0);

        // Burst of 3 periods of 6.
        enable = 0;
        wait_busy(1'b0, 60, b);
        do_update(2, 6, 3, 1, 2, 0);
        enable = 1;
        wait_busy(1'b1, 20, b);
        np = int'(prf); nd = 0; fall_at = -1; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            np += int'(prf);
            if (burst_done) begin nd++; done_at = tcyc; end
            if (!busy) begin fall_at = tcyc; break; end
        end
        chk("burst_prf_count", np, 3);
        chk("burst_busy_fall", fall_at - b, 18);
        chk("burst_done_at_fall", done_at - b, 18);
        chk("burst_done_once", nd, 1);
        nb = 0;
        repeat (10) begin step(); nb += int'(busy) + int'(burst_done); end
        chk("burst_no_restart", nb, 0);

        // Reset in the middle of a run with a long calibration gate.
        enable = 0;
        step();
        do_update(1, 10, 1, 2, 3, 50);
        enable = 1;
        wait_prf(30, p);
        chk("ct_with_first_prf", longint'(ct), 1);
        repeat (4) step();
        rst = 0;
        step();
        chk("reset_mid_run", outs_now(), 0);
        rst = 1; nb = 0;
        repeat (15) begin step(); nb += int'(busy); end
        chk("no_start_after_reset", nb, 0);

        // Randomised traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) < 5) begin
                int r;
                r = $urandom_range(0, 15);
                mode      = (r < 8) ? 2'b01 : (r < 14) ? 2'b10 : 2'($urandom_range(0, 3));
                period    = CW'($urandom_range(0, 14));
                burst_len = 16'($urandom_range(0, 4));
                ct_len    = CW'($urandom_range(0, 25));
                for (int k = 0; k < NCH; k++) begin
                    ch_delay[k*CW +: CW] = CW'($urandom_range(0, 14));
                    ch_width[k*CW +: CW] = CW'($urandom_range(0, 9));
                end
                update = 1'b1;
            end else begin
                update = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            step();
        end
        update = 0; rst = 1;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
